// File: rtl/hub75_rx.sv
// hub75_rx: receive-side model of a HUB75-style LED matrix link.
// Synchronizes the panel pins to clk, rebuilds each shifted row in two
// COLS x 3 shift registers, and on every latch replays the row as a stream
// of pixel writes (top half columns 0..COLS-1, then bottom half).
//
// Optional feature macro: HUB75_RX_BLANK_GATE_EN
//   defined   -> an ARM state holds the replay until synchronized blank is low;
//                the row address is taken from abc when the replay starts.
//   undefined -> replay starts on the latch, abc captured at the latch,
//                blank is synchronized but otherwise unused.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   sclk, lat, blank    panel shift clock, latch, blank
//   r1,g1,b1 / r2,g2,b2 top / bottom half serial data
//   abc                 row address
//   wr_en/half/row/col/rgb  pixel write beat (registered)
//   row_done, frame_done    end-of-row / end-of-frame pulses
//   col_err, ovr_err        sticky error flags (cleared only by reset)
module hub75_rx #(
  parameter int unsigned COLS        = 32,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned SYNC_STAGES = 2   // minimum 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      lat,
  input  logic                      blank,
  input  logic                      r1,
  input  logic                      g1,
  input  logic                      b1,
  input  logic                      r2,
  input  logic                      g2,
  input  logic                      b2,
  input  logic [$clog2(ROWS)-1:0]   abc,
  output logic                      wr_en,
  output logic                      wr_half,
  output logic [$clog2(ROWS)-1:0]   wr_row,
  output logic [$clog2(COLS)-1:0]   wr_col,
  output logic [2:0]                wr_rgb,
  output logic                      row_done,
  output logic                      frame_done,
  output logic                      col_err,
  output logic                      ovr_err
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned NB   = 2 * COLS;
  localparam int unsigned BW   = $clog2(NB);
  localparam int unsigned CNTW = $clog2(COLS + 2);
  localparam int unsigned NIN  = 9 + RW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef HUB75_RX_BLANK_GATE_EN
    S_ARM  = 2'd1,
`endif
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Input synchronizers: all panel pins share one multi-stage pipeline.
  logic [NIN-1:0]                  in_raw, in_s;
  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic                            sclk_s, lat_s, blank_s;
  logic [2:0]                      top_s, bot_s;
  logic [RW-1:0]                   abc_s;
  logic                            sclk_d, lat_d;
  logic                            sclk_rise, lat_rise, latch_go;

  assign in_raw = {sclk, lat, blank, r1, g1, b1, r2, g2, b2, abc};
  assign in_s   = sync_q[SYNC_STAGES-1];

  assign sclk_s  = in_s[NIN-1];
  assign lat_s   = in_s[NIN-2];
  assign blank_s = in_s[NIN-3];
  assign top_s   = in_s[NIN-4 -: 3];
  assign bot_s   = in_s[NIN-7 -: 3];
  assign abc_s   = in_s[RW-1:0];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign lat_rise  = lat_s & ~lat_d;
  assign latch_go  = lat_rise & (state == S_IDLE);

`ifndef HUB75_RX_BLANK_GATE_EN
  logic unused_blank;
  assign unused_blank = blank_s;
`endif

  // Shift registers: new bits enter at the top so the first bit after a
  // latch ends up in column 0 once COLS bits have been shifted.
  logic [COLS-1:0][2:0] top_sr, bot_sr, top_sr_n, bot_sr_n;
  logic [COLS-1:0][2:0] hold_top, hold_bot;
  logic [CNTW-1:0]      bit_cnt, cnt_n;

  // Post-shift view, so a latch in the same cycle as a shift sees the new bit.
  always_comb begin
    top_sr_n = top_sr;
    bot_sr_n = bot_sr;
    cnt_n    = bit_cnt;
    if (sclk_rise) begin
      top_sr_n = {top_s, top_sr[COLS-1:1]};
      bot_sr_n = {bot_s, bot_sr[COLS-1:1]};
      if (bit_cnt != CNTW'(COLS + 1)) cnt_n = bit_cnt + CNTW'(1);
    end
  end

  // Synchronizers, edge detect, shifting, latching and sticky errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      sclk_d   <= 1'b0;
      lat_d    <= 1'b0;
      top_sr   <= '0;
      bot_sr   <= '0;
      hold_top <= '0;
      hold_bot <= '0;
      bit_cnt  <= '0;
      col_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
      sclk_d <= sclk_s;
      lat_d  <= lat_s;
      top_sr <= top_sr_n;
      bot_sr <= bot_sr_n;
      bit_cnt <= lat_rise ? '0 : cnt_n;
      if (lat_rise && (cnt_n != CNTW'(COLS))) col_err <= 1'b1;
      if (lat_rise && (state != S_IDLE))      ovr_err <= 1'b1;
      if (latch_go) begin
        hold_top <= top_sr_n;
        hold_bot <= bot_sr_n;
      end
    end
  end

  // Replay FSM: next state plus the next value of every registered output.
  logic [BW-1:0] beat, beat_n, emit_beat;
  logic          emit, use_load;
  logic          en_n, half_n, done_n, frame_n;
  logic [CW-1:0] col_n;
  logic [2:0]    rgb_n;
  logic [RW-1:0] row_n;

  always_comb begin
    state_n   = state;
    beat_n    = beat;
    row_n     = wr_row;
    emit      = 1'b0;
    emit_beat = '0;
    use_load  = 1'b0;
    done_n    = 1'b0;
    frame_n   = 1'b0;
    en_n      = 1'b0;
    half_n    = 1'b0;
    col_n     = '0;
    rgb_n     = '0;

    case (state)
      S_IDLE: begin
        if (lat_rise) begin
`ifdef HUB75_RX_BLANK_GATE_EN
          state_n = S_ARM;
`else
          // Holding registers load on this edge, so beat 0 reads the load value.
          state_n  = S_DUMP;
          beat_n   = '0;
          emit     = 1'b1;
          use_load = 1'b1;
          row_n    = abc_s;
`endif
        end
      end
`ifdef HUB75_RX_BLANK_GATE_EN
      S_ARM: begin
        if (!blank_s) begin
          state_n = S_DUMP;
          beat_n  = '0;
          emit    = 1'b1;
          row_n   = abc_s;
        end
      end
`endif
      S_DUMP: begin
        if (beat == BW'(NB - 1)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          frame_n = (wr_row == RW'(ROWS - 1));
        end else begin
          beat_n    = beat + BW'(1);
          emit      = 1'b1;
          emit_beat = beat + BW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Beat index -> half/column/pixel for the write presented next cycle.
    if (emit) begin
      en_n   = 1'b1;
      half_n = (emit_beat >= BW'(COLS));
      col_n  = half_n ? CW'(emit_beat - BW'(COLS)) : CW'(emit_beat);
      if (half_n) rgb_n = use_load ? bot_sr_n[col_n] : hold_bot[col_n];
      else        rgb_n = use_load ? top_sr_n[col_n] : hold_top[col_n];
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      beat       <= '0;
      wr_en      <= 1'b0;
      wr_half    <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_rgb     <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      wr_en      <= en_n;
      wr_half    <= half_n;
      wr_row     <= row_n;
      wr_col     <= col_n;
      wr_rgb     <= rgb_n;
      row_done   <= done_n;
      frame_done <= frame_n;
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Testbench for hub75_rx: drives a HUB75 shifting driver, captures the
// replayed pixel writes and checks them against a row-level model.
module tb_hub75_rx;

  localparam int COLS = 32;
  localparam int ROWS = 8;
`ifdef HUB75_RX_BLANK_GATE_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 3;
`endif

  typedef struct packed {
    logic       half;
    logic [2:0] row;
    logic [4:0] col;
    logic [2:0] rgb;
  } wr_t;

  typedef struct {
    int nshift;
    int abc;
    int pat;
    int exp_col_err;
    int exp_fd;
  } vec_t;

  logic       clk, rst_n;
  logic       sclk, lat, blank, r1, g1, b1, r2, g2, b2;
  logic [2:0] abc;
  logic       wr_en, wr_half, row_done, frame_done, col_err, ovr_err;
  logic [2:0] wr_row, wr_rgb;
  logic [4:0] wr_col;

  hub75_rx #(.COLS(COLS), .ROWS(ROWS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst_n),
    .sclk(sclk), .lat(lat), .blank(blank),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .abc(abc),
    .wr_en(wr_en), .wr_half(wr_half), .wr_row(wr_row), .wr_col(wr_col),
    .wr_rgb(wr_rgb), .row_done(row_done), .frame_done(frame_done),
    .col_err(col_err), .ovr_err(ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  wr_t  cap[$];
  wr_t  expq[$];
  int   runs[$];
  int   run, rd_cnt, rd_gap, fd_cnt, fd_bad;
  int   cyc = 0;
  int   first_en_cyc, lat_cyc;
  logic prev_en = 1'b0;
  logic [2:0] tbits[0:39];
  logic [2:0] bbits[0:39];

  // Output monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    wr_t w;
    #1;
    cyc++;
    if (wr_en) begin
      w = {wr_half, wr_row, wr_col, wr_rgb};
      cap.push_back(w);
      run++;
      if (!prev_en && first_en_cyc < 0) first_en_cyc = cyc;
    end else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
    if (row_done) begin
      rd_cnt++;
      if (!prev_en) rd_gap++;
    end
    if (frame_done) begin
      fd_cnt++;
      if (!row_done || wr_row != 3'd7) fd_bad++;
    end
    prev_en = wr_en;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    cap.delete();
    expq.delete();
    runs.delete();
    run = 0; rd_cnt = 0; rd_gap = 0; fd_cnt = 0; fd_bad = 0;
    first_en_cyc = -1;
  endtask

  task automatic idle_inputs();
    sclk = 0; lat = 0; blank = 0; abc = 0;
    {r1, g1, b1, r2, g2, b2} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(3);
  endtask

  // pat 0: top col k = {k[0],0,0}, bottom all ones; pat 1: random.
  task automatic fill(int pat);
    for (int k = 0; k < 40; k++) begin
      logic [5:0] kk;
      kk = 6'(k);
      if (pat == 0) begin
        tbits[k] = {kk[0], 2'b00};
        bbits[k] = 3'b111;
      end else begin
        tbits[k] = 3'($urandom);
        bbits[k] = 3'($urandom);
      end
    end
  endtask

  // Expected replay of one complete row: top columns then bottom columns.
  task automatic model_row(int a);
    wr_t w;
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < COLS; k++) begin
        w.half = 1'(h);
        w.row  = 3'(a);
        w.col  = 5'(k);
        w.rgb  = (h == 0) ? tbits[k] : bbits[k];
        expq.push_back(w);
      end
  endtask

  task automatic shift_bit(logic [2:0] t, logic [2:0] b);
    {r1, g1, b1} = t;
    {r2, g2, b2} = b;
    sclk = 0;
    tick(2);
    sclk = 1;
    tick(2);
    sclk = 0;
  endtask

  task automatic latch(int a);
    abc = 3'(a);
    lat = 1;
    lat_cyc = cyc;
    tick(2);
    lat = 0;
    tick(2);
  endtask

  task automatic send_row(int n, int a);
    for (int i = 0; i < n; i++) shift_bit(tbits[i], bbits[i]);
    latch(a);
  endtask

  function automatic int diff_cnt();
    int d;
    int n;
    d = (cap.size() > expq.size()) ? cap.size() - expq.size() : expq.size() - cap.size();
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) if (cap[i] != expq[i]) d++;
    return d;
  endfunction

  task automatic check_runs(string name, int nexp);
    int b;
    b = 0;
    check({name, "_runs"}, runs.size(), nexp);
    foreach (runs[i]) if (runs[i] != 2 * COLS) b++;
    check({name, "_runlen"}, b, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   nfd;
    int   a;
    int   w;
    int   badrow;

    tbl[0] = '{32, 5, 0, 0, 0};
    tbl[1] = '{31, 2, 0, 1, 0};
    tbl[2] = '{33, 3, 1, 1, 0};
    tbl[3] = '{32, 7, 1, 0, 1};
    tbl[4] = '{32, 0, 1, 0, 0};

    idle_inputs();
    rst_n = 0;
    clear_mon();

    // Reset held: toggling inputs must leave every output at 0.
    for (int i = 0; i < 12; i++) begin
      {sclk, lat, blank, r1, g1, b1, r2, g2, b2, abc} = 12'($urandom);
      tick(1);
      check("reset_outputs",
            int'({wr_en, wr_half, wr_row, wr_col, wr_rgb, row_done, frame_done, col_err, ovr_err}), 0);
    end

    // Table-driven single rows.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      clear_mon();
      fill(tbl[i].pat);
      model_row(tbl[i].abc);
      send_row(tbl[i].nshift, tbl[i].abc);
      tick(80);
      check("row_beats", cap.size(), 2 * COLS);
      check_runs("row", 1);
      check("row_done_cnt", rd_cnt, 1);
      check("row_done_gap", rd_gap, 0);
      check("frame_done_cnt", fd_cnt, tbl[i].exp_fd);
      check("frame_done_align", fd_bad, 0);
      check("col_err", int'(col_err), tbl[i].exp_col_err);
      check("ovr_err_clear", int'(ovr_err), 0);
      if (tbl[i].nshift == COLS) check("row_pixels", diff_cnt(), 0);
      else begin
        badrow = 0;
        foreach (cap[j]) if (cap[j].row != 3'(tbl[i].abc)) badrow++;
        check("row_addr", badrow, 0);
      end
      if (i == 0) check("latch_latency", first_en_cyc - lat_cyc, EXP_LAT);
    end

    // sclk rise and lat rise together: the last bit counts and is latched.
    do_reset();
    clear_mon();
    fill(1);
    model_row(3);
    for (int i = 0; i < COLS - 1; i++) shift_bit(tbits[i], bbits[i]);
    {r1, g1, b1} = tbits[COLS-1];
    {r2, g2, b2} = bbits[COLS-1];
    abc = 3'd3;
    tick(2);
    sclk = 1;
    lat  = 1;
    lat_cyc = cyc;
    tick(2);
    sclk = 0;
    lat  = 0;
    tick(80);
    check("coinc_col_err", int'(col_err), 0);
    check("coinc_pixels", diff_cnt(), 0);
    check("coinc_row_done", rd_cnt, 1);

    // Second latch 10 cycles after the first lands mid-replay.
    do_reset();
    clear_mon();
    fill(1);
    model_row(1);
    send_row(COLS, 1);
    tick(6);
    latch(2);
    tick(80);
    check("ovr_err_set", int'(ovr_err), 1);
    check("ovr_col_err", int'(col_err), 1);
    check("ovr_first_pixels", diff_cnt(), 0);
    check("ovr_row_done", rd_cnt, 1);
    check_runs("ovr", 1);
    clear_mon();
    fill(1);
    model_row(2);
    send_row(COLS, 2);
    tick(80);
    check("ovr_next_pixels", diff_cnt(), 0);
    check("ovr_next_row_done", rd_cnt, 1);

    // Two pipelined frames of random data: in-order rows, then random rows.
    do_reset();
    clear_mon();
    nfd = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++) begin
        a = (f == 0) ? r : int'($urandom_range(0, ROWS - 1));
        if (a == ROWS - 1) nfd++;
        fill(1);
        model_row(a);
        send_row(COLS, a);
      end
    tick(80);
    check("frame_pixels", diff_cnt(), 0);
    check("frame_row_done", rd_cnt, 2 * ROWS);
    check("frame_done_cnt", fd_cnt, nfd);
    check("frame_done_align", fd_bad, 0);
    check("frame_row_done_gap", rd_gap, 0);
    check_runs("frame", 2 * ROWS);
    check("frame_col_err", int'(col_err), 0);
    check("frame_ovr_err", int'(ovr_err), 0);

`ifdef HUB75_RX_BLANK_GATE_EN
    // Blank held high: no replay until it drops; abc sampled at that point.
    do_reset();
    clear_mon();
    fill(1);
    blank = 1;
    send_row(COLS, 4);
    tick(20);
    check("gate_hold", cap.size(), 0);
    model_row(6);
    abc   = 3'd6;
    blank = 0;
    tick(80);
    check("gate_pixels", diff_cnt(), 0);
    check("gate_row_done", rd_cnt, 1);
`endif

    // Reset during a replay aborts it with no row_done.
    do_reset();
    clear_mon();
    fill(1);
    send_row(COLS, 2);
    w = 0;
    while (!wr_en && w < 100) begin
      tick(1);
      w++;
    end
    check("abort_dump_seen", int'(wr_en), 1);
    tick(10);
    rst_n = 0;
    #1;
    check("abort_wr_en_async", int'(wr_en), 0);
    tick(3);
    rst_n = 1;
    tick(80);
    check("abort_no_row_done", rd_cnt, 0);
    check("abort_partial", int'(cap.size() < 2 * COLS), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
